// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl_pkg
// Brief   : Shared state encodings and register constants for the pipeline
//           hazard sequencer, its decoder and debug views.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // dmem wait FSM state encoding (visible externally on fsm_state)
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } hz_state_t;

    // Architectural zero register: writes to it never create a dependency
    localparam logic [4:0] c_REG_ZERO = 5'd0;

    // Width of the consecutive-wait counter (covers MEM_TIMEOUT up to 255)
    localparam int c_WAIT_W = 8;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that increments by one when inc is high and sticks at
//           all-ones instead of wrapping. Asynchronous active-low clear.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;

    // Count qualifying cycles, holding at full scale once reached
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Central stall/flush sequencer for the 5-stage pipeline. Resolves
//           load-use, taken-branch and multi-cycle dmem hazards, runs the dmem
//           wait/timeout FSM and keeps saturating stall/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs0,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs0_used,
    input  logic             id_rs1_used,
    input  logic [4:0]       ex_rf_wa,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Last wait count before the next unacked edge becomes a timeout
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    hz_state_t           r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;

    logic w_lu;
    logic w_br;
    logic w_mw;
    logic w_err;
    logic w_br_flush;

    // Hazard detection: loaded value needed by the instruction right behind it
    assign w_lu = ex_is_load && ex_rf_we && (ex_rf_wa != c_REG_ZERO) &&
                  ((id_rs0_used && (id_rs0 == ex_rf_wa)) ||
                   (id_rs1_used && (id_rs1 == ex_rf_wa)));
    assign w_br  = ex_br_taken;
    assign w_err = (r_state == ST_ERR);
    assign w_mw  = ((r_state == ST_MEM_WAIT) || (r_state == ST_RUN)) &&
                   mem_req && !mem_ack;

    // Branch flush only counts when no memory hold overrides it
    assign w_br_flush = rst && !w_err && !w_mw && w_br;

    // Prioritised stall/flush decode; reset forces bubbles everywhere
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_err || w_mw) begin
            // Freeze everything up to MEM; WB receives a bubble
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (w_br) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (w_lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // dmem wait FSM with timeout; ERR is absorbing until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= r_mem_err || (r_state == ST_ERR);
            case (r_state)
                ST_RUN: begin
                    if (mem_req && !mem_ack) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= c_WAIT_ONE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack || !mem_req) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign fsm_state = r_state;
    assign mem_err   = r_mem_err;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_br_flush),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire
